// File: rtl/rng_draw_scheduler.sv
// Round-robin scheduler sharing one LFSR random-number datapath between NUM_REQ requesters.
// Optional RNG_LOCKUP_RECOVER_EN: treat a caught all-zero value as LFSR lockup and reseed instead of responding.
module rng_draw_scheduler #(
  parameter int unsigned       NUM_REQ         = 4,
  parameter int unsigned       WIDTH           = 4,
  parameter int unsigned       SHIFTS_PER_DRAW = 4,
  parameter logic [WIDTH-1:0]  DEFAULT_SEED    = WIDTH'(4'b1001)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic [WIDTH-1:0]   cfg_seed,
  input  logic               cfg_seed_wr,
  input  logic [WIDTH-1:0]   rng_in,
  output logic               load_shift,
  output logic [WIDTH-1:0]   seed,
  output logic               number_catch,
  output logic [NUM_REQ-1:0] grant,
  output logic               rsp_valid,
  output logic [WIDTH-1:0]   rsp_data,
  output logic               busy
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [2:0] {INIT, IDLE, ARB, MIX, CATCH, RESP} state_t;

  state_t           state;
  logic [IDX_W-1:0] rr_last;
  logic [IDX_W-1:0] cur;
  logic [IDX_W-1:0] pick;
  logic             pick_vld;
  logic [CNT_W-1:0] cnt;
  logic             pending_seed;
  logic             lockup;
  logic             resp_ok;

`ifdef RNG_LOCKUP_RECOVER_EN
  logic [IDX_W-1:0] rr_prev;
  assign lockup = (rng_in == '0);
`else
  assign lockup = 1'b0;
`endif

  // First set request after rr_last (with wrap); descending scan so the nearest one wins.
  always_comb begin
    int idx;
    pick     = '0;
    pick_vld = 1'b0;
    idx      = 0;
    for (int i = int'(NUM_REQ); i > 0; i--) begin
      idx = (int'(rr_last) + i) % int'(NUM_REQ);
      if (req[IDX_W'(idx)]) begin
        pick     = IDX_W'(idx);
        pick_vld = 1'b1;
      end
    end
  end

  // The caught value only exists during RESP, so the response is qualified live from rng_in and req.
  assign resp_ok   = (state == RESP) && req[cur] && !lockup;
  assign rsp_valid = resp_ok;
  assign grant     = resp_ok ? (NUM_REQ'(1) << cur) : '0;
  assign rsp_data  = resp_ok ? rng_in : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= INIT;
      load_shift   <= 1'b0;
      number_catch <= 1'b0;
      busy         <= 1'b0;
      seed         <= DEFAULT_SEED;
      pending_seed <= 1'b0;
      rr_last      <= IDX_W'(NUM_REQ - 1);
      cur          <= '0;
      cnt          <= '0;
`ifdef RNG_LOCKUP_RECOVER_EN
      rr_prev      <= IDX_W'(NUM_REQ - 1);
`endif
    end else begin
      load_shift   <= 1'b0;
      number_catch <= 1'b0;
      case (state)
        // Entered with load_shift already set, except straight out of reset.
        INIT: begin
          if (load_shift) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            load_shift <= 1'b1;
            busy       <= 1'b1;
          end
        end
        IDLE: begin
          if (pending_seed) begin
            pending_seed <= 1'b0;
            load_shift   <= 1'b1;
            busy         <= 1'b1;
            state        <= INIT;
          end else if (|req) begin
            busy  <= 1'b1;
            state <= ARB;
          end
        end
        ARB: begin
          if (pick_vld) begin
            cur     <= pick;
            rr_last <= pick;
`ifdef RNG_LOCKUP_RECOVER_EN
            rr_prev <= rr_last;
`endif
            cnt     <= '0;
            state   <= MIX;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        MIX: begin
          if (cnt == CNT_W'(SHIFTS_PER_DRAW - 1)) begin
            number_catch <= 1'b1;
            state        <= CATCH;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        CATCH: state <= RESP;
        RESP: begin
`ifdef RNG_LOCKUP_RECOVER_EN
          if (lockup) begin
            rr_last    <= rr_prev;
            load_shift <= 1'b1;
            state      <= INIT;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
`else
          busy  <= 1'b0;
          state <= IDLE;
`endif
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
      // Zero seeds would lock the LFSR; reload is deferred to the next IDLE.
      if (cfg_seed_wr && (cfg_seed != '0)) begin
        seed         <= cfg_seed;
        pending_seed <= 1'b1;
      end
    end
  end

endmodule

// File: doc/rng_draw_scheduler.md
Name: rng_draw_scheduler

Overview:
- Sequences the 4-bit LFSR random-number datapath and shares it between several requesters.
- Drives the datapath's seed load, seed value and number-catch strobe, and reads back the caught value.
- Grants draws round-robin over a valid/grant response.
- Sits between the LFSR datapath and consumer logic such as game/dice FSMs and display muxes.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
WIDTH, 4, random value width; matches datapath seed/RNG width
SHIFTS_PER_DRAW, 4, free-run cycles between draws (1..15)
DEFAULT_SEED, 4'b1001, seed loaded after reset; must be nonzero

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
req  in  NUM_REQ  per-requester draw request; level, held until granted
cfg_seed  in  WIDTH  new seed value
cfg_seed_wr  in  1  one-cycle strobe; write cfg_seed
rng_in  in  WIDTH  caught value from the datapath register
load_shift  out  1  datapath seed-load enable
seed  out  WIDTH  seed presented to the datapath
number_catch  out  1  catch strobe to the datapath register; flop-driven, glitch-free
grant  out  NUM_REQ  one-hot; high with rsp_valid only
rsp_valid  out  1  response valid, one cycle
rsp_data  out  WIDTH  drawn value; 0 when rsp_valid is low
busy  out  1  high in any state except IDLE

Behaviour:
- Clock is clk. Reset is reset: synchronous, active-high.
- Reset values: load_shift=0, number_catch=0, grant=0, rsp_valid=0, rsp_data=0, busy=0, seed=DEFAULT_SEED, pending_seed=0, rr_last=NUM_REQ-1, state=INIT.
- Reset mid-operation aborts any draw silently. No response is issued.
- States and transitions:
  - INIT: load_shift=1 for exactly 1 cycle, then IDLE.
  - IDLE: if pending_seed=1, go to INIT and clear pending_seed; this has priority over req. Otherwise, if any req bit is high, go to ARB.
  - ARB: pick the first set req bit searching from rr_last+1 with wrap. Latch it as cur and set rr_last=cur. Clear the shift counter. Go to MIX.
  - MIX: stay SHIFTS_PER_DRAW cycles while the LFSR free-runs, then go to CATCH.
  - CATCH: number_catch=1 for exactly 1 cycle, then RESP.
  - RESP: if req[cur] is still high, drive rsp_valid=1, grant[cur]=1 and rsp_data=rng_in for 1 cycle. If req[cur] has dropped, discard the value: no rsp_valid, rr_last still advanced. Go to IDLE.
- Latency: req first seen high in IDLE at cycle t gives number_catch at t+2+SHIFTS_PER_DRAW and rsp_valid at t+3+SHIFTS_PER_DRAW. With defaults: t+6 and t+7.
- Throughput: back-to-back held requests cost SHIFTS_PER_DRAW+4 cycles per draw.
- cfg_seed_wr handling:
  - A zero cfg_seed is ignored.
  - A nonzero cfg_seed updates the seed register and sets pending_seed.
  - The reload happens on the next IDLE, so a draw in flight completes first.
  - Two writes before the reload: the last one wins.
- Round-robin pointer:
  - Wraps NUM_REQ-1 to 0.
  - A requester is served at most once per arbitration pass while others wait.
  - Request bits other than cur that change during MIX/CATCH are not evaluated until the next ARB.
- Simultaneous cfg_seed_wr and req in IDLE: the seed write is registered that cycle, so the request is arbitrated first. The reload happens after that draw.

Optional Feature:
RNG_LOCKUP_RECOVER_EN
- Defined: in RESP, rng_in==0 means the LFSR is stuck at all-zero.
  - Suppress the response (no rsp_valid, no grant) and restore rr_last to its pre-ARB value.
  - Go to INIT, reloading the current seed, then IDLE.
  - cur's still-held req is redrawn normally.
- Not defined: a zero rng_in is returned as rsp_data=0 with rsp_valid and grant.

Test Plan:
- Release reset -> load_shift=1 for exactly one cycle with seed=4'b1001; busy=1 that cycle, then busy=0.
- req=4'b0001 held from cycle t -> number_catch=1 at t+6; rsp_valid=1, grant=4'b0001 at t+7; rsp_data equals the model LFSR value sampled on the catch edge.
- req=4'b1111 held -> grants 0001, 0010, 0100, 1000, 0001 in order, 8 cycles apart.
- req=4'b0010 raised, then dropped during MIX -> no rsp_valid. A following req=4'b0110 is granted bit 2 first.
- cfg_seed_wr with 4'b0000 -> no effect. cfg_seed_wr with 4'b0110 mid-draw -> current rsp_valid still delivered, then load_shift pulses with seed=4'b0110.
- Stub rng_in=0 with req0 held -> with RNG_LOCKUP_RECOVER_EN: no response, load_shift pulse, redraw issued. Without it: rsp_valid with rsp_data=0.
